// File: rtl/k005297_pkg.sv
// Shared definitions for the k005297 host-bus arbiter: FSM encodings and widths.
package k005297_pkg;

    localparam int unsigned WORD_CNT_W = 8;
    localparam int unsigned STATE_W    = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_BACKOFF  = 3'd2;
    localparam logic [2:0] ST_WAIT_REL = 3'd3;
    localparam logic [2:0] ST_OWN      = 3'd4;
    localparam logic [2:0] ST_RELEASE  = 3'd5;

endpackage

// File: rtl/k005297_busarbiter_if.sv
// Handshake/bus signal bundle between the arbiter, the DMA timing block and the 68000 bus.
interface k005297_busarbiter_if;
    import k005297_pkg::*;

    logic                  i_BR_START_n;
    logic                  i_DMA_WORD_END;
    logic                  i_DMA_END;
    logic                  i_CPU_BG_n;
    logic                  i_CPU_AS_n;
    logic                  i_CPU_BGACK_n;
    logic                  o_CPU_BR_n;
    logic                  o_CPU_BGACK_n;
    logic                  o_DMA_ACT;
    logic                  o_GRANT_TMO;
    logic [WORD_CNT_W-1:0] o_WORD_CNT;

    modport slave (
        input  i_BR_START_n, i_DMA_WORD_END, i_DMA_END, i_CPU_BG_n, i_CPU_AS_n, i_CPU_BGACK_n,
        output o_CPU_BR_n, o_CPU_BGACK_n, o_DMA_ACT, o_GRANT_TMO, o_WORD_CNT
    );

    modport master (
        output i_BR_START_n, i_DMA_WORD_END, i_DMA_END, i_CPU_BG_n, i_CPU_AS_n, i_CPU_BGACK_n,
        input  o_CPU_BR_n, o_CPU_BGACK_n, o_DMA_ACT, o_GRANT_TMO, o_WORD_CNT
    );

endinterface

// File: rtl/k005297_tickcnt.sv
// Tick-enabled up-counter with synchronous clear (priority) and terminal-count flag.
module k005297_tickcnt #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TERM  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc_c
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_inc) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end
    end

    assign o_tc_c = (r_cnt == WIDTH'(TERM));

endmodule

// File: rtl/k005297_busarbiter.sv
// 68000 BR/BG/BGACK bus arbiter for the bubble DMA engine.
// Optional burst cap enabled by defining K005297_BUSARB_BURST_LIMIT_EN.
module k005297_busarbiter
    import k005297_pkg::*;
#(
    parameter int unsigned GRANT_TIMEOUT = 64,
    parameter int unsigned BACKOFF_LEN   = 4
`ifdef K005297_BUSARB_BURST_LIMIT_EN
    ,
    parameter int unsigned BURST_MAX     = 16
`endif
) (
    input  logic                   i_MCLK,
    input  logic                   i_SYS_RST_n,
    input  logic                   i_CLK4M_PCEN_n,
    k005297_busarbiter_if.slave    bus
);

    localparam int unsigned TMO_W = $clog2(GRANT_TIMEOUT + 1);
    localparam int unsigned BO_W  = $clog2(BACKOFF_LEN + 1);

    logic                  w_tick;
    logic                  r_bg_n;
    logic                  r_as_n;
    logic                  r_ext_bgack_n;
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_br_n;
    logic                  r_bgack_n;
    logic                  r_dma_act;
    logic                  r_grant_tmo;
    logic [WORD_CNT_W-1:0] r_word_cnt;
    logic                  w_grant_tmo_nxt;
    logic [WORD_CNT_W-1:0] w_word_cnt_nxt;
    logic [WORD_CNT_W-1:0] w_word_cnt_inc;
    logic                  w_tmo_tc;
    logic                  w_bo_tc;

    assign w_tick         = ~i_CLK4M_PCEN_n;
    assign w_word_cnt_inc = r_word_cnt + WORD_CNT_W'(1);

    // One-tick synchroniser stage for the CPU-side bus signals
    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            r_bg_n        <= 1'b1;
            r_as_n        <= 1'b1;
            r_ext_bgack_n <= 1'b1;
        end else if (w_tick) begin
            r_bg_n        <= bus.i_CPU_BG_n;
            r_as_n        <= bus.i_CPU_AS_n;
            r_ext_bgack_n <= bus.i_CPU_BGACK_n;
        end
    end

    k005297_tickcnt #(.WIDTH(TMO_W), .TERM(GRANT_TIMEOUT - 1)) u_tmo_cnt (
        .clk    (i_MCLK),
        .rst_n  (i_SYS_RST_n),
        .i_tick (w_tick),
        .i_clr  (r_state != ST_REQ),
        .i_inc  (r_state == ST_REQ),
        .o_tc_c (w_tmo_tc)
    );

    k005297_tickcnt #(.WIDTH(BO_W), .TERM(BACKOFF_LEN - 1)) u_bo_cnt (
        .clk    (i_MCLK),
        .rst_n  (i_SYS_RST_n),
        .i_tick (w_tick),
        .i_clr  (r_state != ST_BACKOFF),
        .i_inc  (r_state == ST_BACKOFF),
        .o_tc_c (w_bo_tc)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_tmo_nxt = 1'b0;
        w_word_cnt_nxt  = r_word_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!bus.i_BR_START_n) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (!r_bg_n) begin
                    w_state_nxt = ST_WAIT_REL;
                end else if (bus.i_BR_START_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo_tc) begin
                    w_grant_tmo_nxt = 1'b1;
                    w_state_nxt     = ST_BACKOFF;
                end
            end
            ST_BACKOFF: begin
                if (w_bo_tc) w_state_nxt = bus.i_BR_START_n ? ST_IDLE : ST_REQ;
            end
            ST_WAIT_REL: begin
                if (r_as_n && r_ext_bgack_n) w_state_nxt = ST_OWN;
            end
            ST_OWN: begin
                if (bus.i_DMA_WORD_END && (r_word_cnt != '1)) w_word_cnt_nxt = w_word_cnt_inc;
                if (bus.i_DMA_END) begin
                    w_state_nxt = ST_RELEASE;
`ifdef K005297_BUSARB_BURST_LIMIT_EN
                end else if (bus.i_DMA_WORD_END && (w_word_cnt_inc == WORD_CNT_W'(BURST_MAX))) begin
                    w_state_nxt = ST_RELEASE;
`endif
                end
            end
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        // Word count is per ownership; leaving OWN always zeroes it
        if (w_state_nxt == ST_RELEASE) w_word_cnt_nxt = '0;
    end

    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            r_state     <= ST_IDLE;
            r_br_n      <= 1'b1;
            r_bgack_n   <= 1'b1;
            r_dma_act   <= 1'b0;
            r_grant_tmo <= 1'b0;
            r_word_cnt  <= '0;
        end else if (w_tick) begin
            r_state     <= w_state_nxt;
            r_br_n      <= !((w_state_nxt == ST_REQ) || (w_state_nxt == ST_WAIT_REL));
            r_bgack_n   <= (w_state_nxt != ST_OWN);
            r_dma_act   <= (w_state_nxt == ST_OWN);
            r_grant_tmo <= w_grant_tmo_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
        end
    end

    assign bus.o_CPU_BR_n    = r_br_n;
    assign bus.o_CPU_BGACK_n = r_bgack_n;
    assign bus.o_DMA_ACT     = r_dma_act;
    assign bus.o_GRANT_TMO   = r_grant_tmo;
    assign bus.o_WORD_CNT    = r_word_cnt;

endmodule

// File: tb/tb_k005297_busarbiter.sv
// Directed self-checking bench for k005297_busarbiter (4 MHz tick on every second MCLK edge).
module tb_k005297_busarbiter;

    logic clk;
    logic rst_n;
    logic pcen_n;
    int unsigned n_vec;
    int unsigned n_err;

    k005297_busarbiter_if bus();

    k005297_busarbiter dut (
        .i_MCLK         (clk),
        .i_SYS_RST_n    (rst_n),
        .i_CLK4M_PCEN_n (pcen_n),
        .bus            (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        pcen_n = 1'b1;
        forever begin
            @(negedge clk);
            pcen_n = ~pcen_n;
        end
    end

    // Advance to just after the next tick edge
    task automatic tick();
        @(posedge clk);
        while (pcen_n !== 1'b0) @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.i_BR_START_n   = 1'b1;
        bus.i_DMA_WORD_END = 1'b0;
        bus.i_DMA_END      = 1'b1;
        bus.i_CPU_BG_n     = 1'b1;
        bus.i_CPU_AS_n     = 1'b1;
        bus.i_CPU_BGACK_n  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        if (bus.o_CPU_BR_n !== 1'b1) begin n_err++; $display("FAIL reset_br_n: got %b want 1", bus.o_CPU_BR_n); end n_vec++;
        if (bus.o_CPU_BGACK_n !== 1'b1) begin n_err++; $display("FAIL reset_bgack_n: got %b want 1", bus.o_CPU_BGACK_n); end n_vec++;
        if (bus.o_DMA_ACT !== 1'b0) begin n_err++; $display("FAIL reset_dma_act: got %b want 0", bus.o_DMA_ACT); end n_vec++;
        if (bus.o_GRANT_TMO !== 1'b0) begin n_err++; $display("FAIL reset_tmo: got %b want 0", bus.o_GRANT_TMO); end n_vec++;
        if (bus.o_WORD_CNT !== 8'd0) begin n_err++; $display("FAIL reset_word_cnt: got %0d want 0", bus.o_WORD_CNT); end n_vec++;
        rst_n = 1'b1;
        repeat (2) tick();
        if (bus.o_CPU_BR_n !== 1'b1) begin n_err++; $display("FAIL post_reset_br_n: got %b want 1", bus.o_CPU_BR_n); end n_vec++;
    endtask

    task automatic test_basic_grant();
        bus.i_BR_START_n = 1'b0;
        bus.i_DMA_END    = 1'b0;
        @(posedge clk); #1;
        if (bus.o_CPU_BR_n !== 1'b1) begin n_err++; $display("FAIL tick_gate_br_n: got %b want 1", bus.o_CPU_BR_n); end n_vec++;
        tick();
        if (bus.o_CPU_BR_n !== 1'b0) begin n_err++; $display("FAIL grant_br_fall: got %b want 0", bus.o_CPU_BR_n); end n_vec++;
        repeat (2) tick();
        bus.i_CPU_BG_n = 1'b0;
        tick();
        if (bus.o_CPU_BGACK_n !== 1'b1) begin n_err++; $display("FAIL grant_bg_reg_bgack: got %b want 1", bus.o_CPU_BGACK_n); end n_vec++;
        tick();
        if (bus.o_CPU_BGACK_n !== 1'b1 || bus.o_CPU_BR_n !== 1'b0) begin
            n_err++; $display("FAIL grant_wait_rel: got bgack_n=%b br_n=%b want 1 0", bus.o_CPU_BGACK_n, bus.o_CPU_BR_n);
        end n_vec++;
        tick();
        if (bus.o_CPU_BGACK_n !== 1'b0 || bus.o_DMA_ACT !== 1'b1 || bus.o_CPU_BR_n !== 1'b1) begin
            n_err++; $display("FAIL grant_own: got bgack_n=%b act=%b br_n=%b want 0 1 1", bus.o_CPU_BGACK_n, bus.o_DMA_ACT, bus.o_CPU_BR_n);
        end n_vec++;
        bus.i_CPU_BG_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.i_DMA_WORD_END = 1'b1;
            tick();
            bus.i_DMA_WORD_END = 1'b0;
            tick();
        end
        if (bus.o_WORD_CNT !== 8'd5) begin n_err++; $display("FAIL grant_word_cnt: got %0d want 5", bus.o_WORD_CNT); end n_vec++;
        bus.i_DMA_END    = 1'b1;
        bus.i_BR_START_n = 1'b1;
        tick();
        if (bus.o_CPU_BGACK_n !== 1'b1 || bus.o_DMA_ACT !== 1'b0 || bus.o_WORD_CNT !== 8'd0) begin
            n_err++; $display("FAIL grant_release: got bgack_n=%b act=%b cnt=%0d want 1 0 0", bus.o_CPU_BGACK_n, bus.o_DMA_ACT, bus.o_WORD_CNT);
        end n_vec++;
        repeat (2) tick();
        if (bus.o_CPU_BR_n !== 1'b1) begin n_err++; $display("FAIL grant_idle_br_n: got %b want 1", bus.o_CPU_BR_n); end n_vec++;
    endtask

    task automatic test_timeout();
        set_idle();
        repeat (2) tick();
        bus.i_BR_START_n = 1'b0;
        tick();
        repeat (63) tick();
        if (bus.o_GRANT_TMO !== 1'b0 || bus.o_CPU_BR_n !== 1'b0) begin
            n_err++; $display("FAIL tmo_t63: got tmo=%b br_n=%b want 0 0", bus.o_GRANT_TMO, bus.o_CPU_BR_n);
        end n_vec++;
        tick();
        if (bus.o_GRANT_TMO !== 1'b1 || bus.o_CPU_BR_n !== 1'b1) begin
            n_err++; $display("FAIL tmo_t64: got tmo=%b br_n=%b want 1 1", bus.o_GRANT_TMO, bus.o_CPU_BR_n);
        end n_vec++;
        tick();
        if (bus.o_GRANT_TMO !== 1'b0 || bus.o_CPU_BR_n !== 1'b1) begin
            n_err++; $display("FAIL tmo_t65: got tmo=%b br_n=%b want 0 1", bus.o_GRANT_TMO, bus.o_CPU_BR_n);
        end n_vec++;
        repeat (2) tick();
        if (bus.o_CPU_BR_n !== 1'b1) begin n_err++; $display("FAIL tmo_backoff_end: got %b want 1", bus.o_CPU_BR_n); end n_vec++;
        tick();
        if (bus.o_CPU_BR_n !== 1'b0) begin n_err++; $display("FAIL tmo_rerequest: got %b want 0", bus.o_CPU_BR_n); end n_vec++;
        bus.i_BR_START_n = 1'b1;
        tick();
        if (bus.o_CPU_BR_n !== 1'b1) begin n_err++; $display("FAIL tmo_withdraw: got %b want 1", bus.o_CPU_BR_n); end n_vec++;
    endtask

    task automatic test_bus_busy();
        set_idle();
        repeat (2) tick();
        bus.i_DMA_END    = 1'b0;
        bus.i_CPU_AS_n   = 1'b0;
        bus.i_CPU_BG_n   = 1'b0;
        bus.i_BR_START_n = 1'b0;
        repeat (6) tick();
        if (bus.o_CPU_BGACK_n !== 1'b1 || bus.o_CPU_BR_n !== 1'b0) begin
            n_err++; $display("FAIL busy_as_hold: got bgack_n=%b br_n=%b want 1 0", bus.o_CPU_BGACK_n, bus.o_CPU_BR_n);
        end n_vec++;
        bus.i_CPU_AS_n = 1'b1;
        tick();
        if (bus.o_CPU_BGACK_n !== 1'b1) begin n_err++; $display("FAIL busy_as_reg: got %b want 1", bus.o_CPU_BGACK_n); end n_vec++;
        tick();
        if (bus.o_CPU_BGACK_n !== 1'b0) begin n_err++; $display("FAIL busy_as_own: got %b want 0", bus.o_CPU_BGACK_n); end n_vec++;
        set_idle();
        repeat (3) tick();
        bus.i_DMA_END     = 1'b0;
        bus.i_CPU_BGACK_n = 1'b0;
        bus.i_CPU_BG_n    = 1'b0;
        bus.i_BR_START_n  = 1'b0;
        repeat (4) tick();
        if (bus.o_CPU_BGACK_n !== 1'b1 || bus.o_CPU_BR_n !== 1'b0) begin
            n_err++; $display("FAIL busy_ext_hold: got bgack_n=%b br_n=%b want 1 0", bus.o_CPU_BGACK_n, bus.o_CPU_BR_n);
        end n_vec++;
        bus.i_CPU_BGACK_n = 1'b1;
        tick();
        if (bus.o_CPU_BGACK_n !== 1'b1) begin n_err++; $display("FAIL busy_ext_reg: got %b want 1", bus.o_CPU_BGACK_n); end n_vec++;
        tick();
        if (bus.o_CPU_BGACK_n !== 1'b0) begin n_err++; $display("FAIL busy_ext_own: got %b want 0", bus.o_CPU_BGACK_n); end n_vec++;
        set_idle();
        repeat (3) tick();
    endtask

    task automatic test_burst();
        bus.i_DMA_END    = 1'b0;
        bus.i_CPU_BG_n   = 1'b0;
        bus.i_BR_START_n = 1'b0;
        repeat (3) tick();
        if (bus.o_DMA_ACT !== 1'b1) begin n_err++; $display("FAIL burst_own: got %b want 1", bus.o_DMA_ACT); end n_vec++;
`ifdef K005297_BUSARB_BURST_LIMIT_EN
        for (int i = 1; i <= 16; i++) begin
            bus.i_DMA_WORD_END = 1'b1;
            tick();
            bus.i_DMA_WORD_END = 1'b0;
            if (i == 16 && (bus.o_DMA_ACT !== 1'b0 || bus.o_WORD_CNT !== 8'd0)) begin
                n_err++; $display("FAIL burst_cap_release: got act=%b cnt=%0d want 0 0", bus.o_DMA_ACT, bus.o_WORD_CNT);
            end
            if (i == 16) n_vec++;
            tick();
        end
        repeat (3) tick();
        if (bus.o_DMA_ACT !== 1'b1) begin n_err++; $display("FAIL burst_reown: got %b want 1", bus.o_DMA_ACT); end n_vec++;
        for (int i = 0; i < 4; i++) begin
            bus.i_DMA_WORD_END = 1'b1;
            tick();
            bus.i_DMA_WORD_END = 1'b0;
            tick();
        end
        if (bus.o_WORD_CNT !== 8'd4) begin n_err++; $display("FAIL burst_second_cnt: got %0d want 4", bus.o_WORD_CNT); end n_vec++;
`else
        for (int i = 1; i <= 20; i++) begin
            bus.i_DMA_WORD_END = 1'b1;
            tick();
            bus.i_DMA_WORD_END = 1'b0;
            if (i == 16 && (bus.o_DMA_ACT !== 1'b1 || bus.o_WORD_CNT !== 8'd16)) begin
                n_err++; $display("FAIL burst_no_cap: got act=%b cnt=%0d want 1 16", bus.o_DMA_ACT, bus.o_WORD_CNT);
            end
            if (i == 16) n_vec++;
            tick();
        end
        if (bus.o_WORD_CNT !== 8'd20 || bus.o_DMA_ACT !== 1'b1) begin
            n_err++; $display("FAIL burst_total_cnt: got cnt=%0d act=%b want 20 1", bus.o_WORD_CNT, bus.o_DMA_ACT);
        end n_vec++;
`endif
        set_idle();
        repeat (3) tick();
        if (bus.o_DMA_ACT !== 1'b0) begin n_err++; $display("FAIL burst_end: got %b want 0", bus.o_DMA_ACT); end n_vec++;
    endtask

    task automatic test_async_reset();
        bus.i_DMA_END    = 1'b0;
        bus.i_CPU_BG_n   = 1'b0;
        bus.i_BR_START_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            bus.i_DMA_WORD_END = 1'b1;
            tick();
            bus.i_DMA_WORD_END = 1'b0;
            tick();
        end
        if (bus.o_WORD_CNT !== 8'd3 || bus.o_DMA_ACT !== 1'b1) begin
            n_err++; $display("FAIL arst_pre: got cnt=%0d act=%b want 3 1", bus.o_WORD_CNT, bus.o_DMA_ACT);
        end n_vec++;
        #2 rst_n = 1'b0;
        #1;
        if (bus.o_CPU_BGACK_n !== 1'b1 || bus.o_DMA_ACT !== 1'b0 || bus.o_WORD_CNT !== 8'd0) begin
            n_err++; $display("FAIL arst_immediate: got bgack_n=%b act=%b cnt=%0d want 1 0 0", bus.o_CPU_BGACK_n, bus.o_DMA_ACT, bus.o_WORD_CNT);
        end n_vec++;
        set_idle();
        #1 rst_n = 1'b1;
        tick();
        if (bus.o_CPU_BR_n !== 1'b1 || bus.o_CPU_BGACK_n !== 1'b1) begin
            n_err++; $display("FAIL arst_idle: got br_n=%b bgack_n=%b want 1 1", bus.o_CPU_BR_n, bus.o_CPU_BGACK_n);
        end n_vec++;
        bus.i_BR_START_n = 1'b0;
        tick();
        if (bus.o_CPU_BR_n !== 1'b0) begin n_err++; $display("FAIL arst_rerequest: got %b want 0", bus.o_CPU_BR_n); end n_vec++;
        set_idle();
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_grant();
        test_timeout();
        test_bus_busy();
        test_burst();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
